// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and four-cycle access sequencer for the shared memory.
// A granted access runs MAR load then data transfer; all memory strobes originate here.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_bus,
    output logic              o_mem_mar_write_en,
    output logic              o_mem_write_en,
    output logic              o_mem_out_en,
    input  logic [DATA_W-1:0] i_mem_out
);

    // state | meaning
    // IDLE  | waiting for a request; arbitration happens here
    // ADDR  | latched address on the bus, MAR load strobe
    // DATA  | write data + write strobe, or read output enable
    // DONE  | ack pulse to the served port
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_port;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               w_any_req;
    logic               w_sel;
    logic               w_grant;

    // On a tie the port not served last wins; otherwise the lone requester.
    always_comb begin
        w_any_req = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            w_sel = ~r_last;
        end else begin
            w_sel = i_req1;
        end
        w_grant = (r_state == S_IDLE) && w_any_req;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_ADDR;
            S_ADDR:  w_state_nxt = S_DATA;
            S_DATA:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request attributes are frozen at grant so later port activity cannot disturb the access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_last  <= w_sel;
            r_port  <= w_sel;
            r_we    <= w_sel ? i_we1 : i_we0;
            r_addr  <= w_sel ? i_addr1 : i_addr0;
            r_wdata <= w_sel ? i_wdata1 : i_wdata0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (r_state == S_DATA && !r_we) begin
            r_rdata <= i_mem_out;
        end
    end

    always_comb begin
        o_mem_bus          = '0;
        o_mem_mar_write_en = 1'b0;
        o_mem_write_en     = 1'b0;
        o_mem_out_en       = 1'b0;
        o_ack              = 2'b00;
        case (r_state)
            S_ADDR: begin
                o_mem_bus          = r_addr;
                o_mem_mar_write_en = 1'b1;
            end
            S_DATA: begin
                if (r_we) begin
                    o_mem_bus      = ADDR_W'(r_wdata);
                    o_mem_write_en = 1'b1;
                end else begin
                    o_mem_out_en   = 1'b1;
                end
            end
            S_DONE: begin
                o_ack = r_port ? 2'b10 : 2'b01;
            end
            default: begin
                o_mem_bus = '0;
            end
        endcase
    end

    always_comb begin
        o_busy  = (r_state != S_IDLE);
        o_gnt   = o_busy ? (r_port ? 2'b10 : 2'b01) : 2'b00;
        o_rdata = r_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory and a reference
// model of arbitration order and memory contents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic [1:0]  gnt, ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [15:0] mem_bus;
    logic        mar_we, mem_we, mem_oe;
    logic [7:0]  mem_out;

    int checks = 0;
    int errors = 0;

    // behavioural memory: MAR register, write port, combinational read
    logic [7:0]  mem [0:65535];
    logic [15:0] mar = '0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    // reference model state
    logic [7:0]  ref_mem [0:65535];
    bit          m_last;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mar] <= mem_bus[7:0];
        if (mar_we) mar <= mem_bus;
    end
    assign mem_out = mem[mar];

    mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt(gnt), .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
        .o_mem_bus(mem_bus), .o_mem_mar_write_en(mar_we),
        .o_mem_write_en(mem_we), .o_mem_out_en(mem_oe), .i_mem_out(mem_out)
    );

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({mar_we, mem_we, mem_oe} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {mar_we, mem_we, mem_oe}); end
        checks++; if (mem_bus !== 16'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0000", mem_bus); end
        checks++; if (rdata !== 8'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        rst_n = 1'b1;
        m_last = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_read();
        preload(16'h0010, 8'hA5);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        @(negedge clk);
        checks++; if ({mar_we, mem_we, mem_oe} !== 3'b100) begin errors++; $display("FAIL rd_addr_strobes got=%b exp=100", {mar_we, mem_we, mem_oe}); end
        checks++; if (mem_bus !== 16'h0010) begin errors++; $display("FAIL rd_addr_bus got=%h exp=0010", mem_bus); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt got=%b exp=01", gnt); end
        @(negedge clk);
        checks++; if ({mar_we, mem_we, mem_oe} !== 3'b001) begin errors++; $display("FAIL rd_data_strobes got=%b exp=001", {mar_we, mem_we, mem_oe}); end
        checks++; if (mem_bus !== 16'h0) begin errors++; $display("FAIL rd_data_bus got=%h exp=0000", mem_bus); end
        @(negedge clk);
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rd_ack got=%b exp=01", ack); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ack !== 2'b00) begin errors++; $display("FAIL rd_end got busy=%b ack=%b exp busy=0 ack=00", busy, ack); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL rd_hold got=%h exp=a5", rdata); end
        m_last = 1'b0;
    endtask

    task automatic test_write_readback();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h00FE; wdata1 = 8'h3C;
        @(negedge clk);
        checks++; if (mem_bus !== 16'h00FE || mar_we !== 1'b1) begin errors++; $display("FAIL wr_addr got bus=%h mar=%b exp bus=00fe mar=1", mem_bus, mar_we); end
        @(negedge clk);
        checks++; if (mem_bus !== 16'h003C || mem_we !== 1'b1) begin errors++; $display("FAIL wr_data got bus=%h we=%b exp bus=003c we=1", mem_bus, mem_we); end
        @(negedge clk);
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL wr_ack got=%b exp=10", ack); end
        req1 = 1'b0;
        ref_mem[16'h00FE] = 8'h3C;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL rb_ack got=%b exp=10", ack); end
        checks++; if (rdata !== ref_mem[16'h00FE]) begin errors++; $display("FAIL rb_rdata got=%h exp=%h", rdata, ref_mem[16'h00FE]); end
        req1 = 1'b0;
        @(negedge clk);
        m_last = 1'b1;
    endtask

    task automatic test_tie();
        bit port;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1'b1;
        we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0010; addr1 = 16'h00FE;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            port = ~m_last;
            m_last = port;
            @(negedge clk);
            checks++; if (gnt !== (port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_gnt[%0d] got=%b exp=%b", k, gnt, port ? 2'b10 : 2'b01); end
            repeat (2) @(negedge clk);
            checks++; if (ack !== (port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_ack[%0d] got=%b exp=%b", k, ack, port ? 2'b10 : 2'b01); end
            if (port) req1 = 1'b0; else req0 = 1'b0;
            @(negedge clk);
            req0 = 1'b1; req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_stability();
        preload(16'h0040, 8'h00);
        preload(16'h0041, 8'h00);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 8'h11;
        @(negedge clk);
        checks++; if (mem_bus !== 16'h0040) begin errors++; $display("FAIL stab_addr got=%h exp=0040", mem_bus); end
        addr0 = 16'h0041; wdata0 = 8'h22; we0 = 1'b0;
        @(negedge clk);
        checks++; if (mem_bus !== 16'h0011 || {mar_we, mem_we, mem_oe} !== 3'b010) begin errors++; $display("FAIL stab_data got bus=%h strobes=%b exp bus=0011 strobes=010", mem_bus, {mar_we, mem_we, mem_oe}); end
        wdata0 = 8'h33;
        @(negedge clk);
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL stab_ack got=%b exp=01", ack); end
        req0 = 1'b0;
        ref_mem[16'h0040] = 8'h11;
        @(negedge clk);
        checks++; if (mem[16'h0040] !== ref_mem[16'h0040] || mem[16'h0041] !== ref_mem[16'h0041]) begin errors++; $display("FAIL stab_mem got=%h,%h exp=%h,%h", mem[16'h0040], mem[16'h0041], ref_mem[16'h0040], ref_mem[16'h0041]); end
        m_last = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        preload(16'h0020, 8'h5A);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 8'h77;
        @(negedge clk);
        checks++; if (mar_we !== 1'b1) begin errors++; $display("FAIL rmw_in_addr got=%b exp=1", mar_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({gnt, ack, busy, mar_we, mem_we, mem_oe} !== 8'h00 || mem_bus !== 16'h0 || rdata !== 8'h0) begin
            errors++; $display("FAIL rmw_clear got gnt=%b ack=%b busy=%b str=%b bus=%h rdata=%h exp all 0", gnt, ack, busy, {mar_we, mem_we, mem_oe}, mem_bus, rdata);
        end
        req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rmw_no_ack[%0d] got=%b exp=00", c, ack); end
        end
        rst_n = 1'b1;
        m_last = 1'b1;
        @(negedge clk);
        checks++; if (mem[16'h0020] !== ref_mem[16'h0020]) begin errors++; $display("FAIL rmw_mem got=%h exp=%h", mem[16'h0020], ref_mem[16'h0020]); end
        we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0010; addr1 = 16'h0010;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmw_tie got=%b exp=01", gnt); end
        repeat (2) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        m_last = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0103;
        for (int c = 0; c < 20 && second < 0; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                checks++; if (ack !== 2'b10) begin errors++; $display("FAIL b2b_ack got=%b exp=10", ack); end
                if (first < 0) first = c;
                else begin
                    second = c;
                    req1 = 1'b0;
                end
            end
        end
        req1 = 1'b0;
        checks++; if (second < 0) begin errors++; $display("FAIL b2b_timeout got first=%0d second=%0d exp two acks", first, second); end
        checks++; if (second - first !== 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", second - first); end
        checks++; if (rdata !== ref_mem[16'h0103]) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", rdata, ref_mem[16'h0103]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
        m_last = 1'b1;
    endtask

    task automatic test_random();
        bit          port, e_we, rd_seen;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata, last_rd;
        int          pat;
        rd_seen = 1'b0; last_rd = '0;
        for (int it = 0; it < 40; it++) begin
            pat = $urandom_range(1, 3);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 16'h0100 + 16'($urandom_range(0, 15));
            addr1 = 16'h0100 + 16'($urandom_range(0, 15));
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            req0 = pat[0]; req1 = pat[1];
            port = (pat == 3) ? ~m_last : (pat == 2);
            m_last = port;
            e_we = port ? we1 : we0;
            e_addr = port ? addr1 : addr0;
            e_wdata = port ? wdata1 : wdata0;
            @(negedge clk);
            checks++; if (gnt !== (port ? 2'b10 : 2'b01) || mem_bus !== e_addr || mar_we !== 1'b1) begin
                errors++; $display("FAIL rnd_addr[%0d] got gnt=%b bus=%h mar=%b exp gnt=%b bus=%h mar=1", it, gnt, mem_bus, mar_we, port ? 2'b10 : 2'b01, e_addr);
            end
            we0 = 1'($urandom); we1 = 1'($urandom); addr0 = 16'($urandom); addr1 = 16'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            @(negedge clk);
            checks++; if ($countones({mar_we, mem_we, mem_oe}) > 1) begin errors++; $display("FAIL rnd_onehot[%0d] got=%b exp at most one", it, {mar_we, mem_we, mem_oe}); end
            checks++; if (mem_we !== e_we || mem_oe !== !e_we || mem_bus !== (e_we ? {8'h00, e_wdata} : 16'h0)) begin
                errors++; $display("FAIL rnd_data[%0d] got we=%b oe=%b bus=%h exp we=%b bus=%h", it, mem_we, mem_oe, mem_bus, e_we, e_we ? {8'h00, e_wdata} : 16'h0);
            end
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            @(negedge clk);
            checks++; if (ack !== (port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", it, ack, port ? 2'b10 : 2'b01); end
            if (e_we) begin
                ref_mem[e_addr] = e_wdata;
                if (rd_seen) begin
                    checks++; if (rdata !== last_rd) begin errors++; $display("FAIL rnd_hold[%0d] got=%h exp=%h", it, rdata, last_rd); end
                end
            end else begin
                last_rd = ref_mem[e_addr];
                rd_seen = 1'b1;
                checks++; if (rdata !== last_rd) begin errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", it, rdata, last_rd); end
            end
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || {mar_we, mem_we, mem_oe} !== 3'b000) begin errors++; $display("FAIL rnd_idle[%0d] got busy=%b str=%b exp 0", it, busy, {mar_we, mem_we, mem_oe}); end
        end
    endtask

    initial begin
        test_reset();
        for (int a = 0; a < 16; a++) preload(16'h0100 + 16'(a), 8'($urandom));
        test_single_read();
        test_write_readback();
        test_tie();
        test_stability();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
